stream_extrema_tracker: RTL and testbench

//  Consumes a framed stream of unsigned WIDTH-bit samples; tracks the running max and min

---
 rtl/stream_extrema_tracker_pkg.sv | 8 +
 rtl/stream_extrema_tracker_cmp.sv | 16 +
 rtl/stream_extrema_tracker.sv | 189 ++++++++++++++++++
 tb/tb_stream_extrema_tracker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_extrema_tracker_pkg.sv
// Shared definitions for the stream extrema tracker: FSM state encodings.
package extrema_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/stream_extrema_tracker_cmp.sv
// Combinational unsigned magnitude comparator: exactly one of gt/eq/lt is set.
module magnitude_cmp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             gt_c,
    output logic             eq_c,
    output logic             lt_c
);

    assign gt_c = (a_i >  b_i);
    assign eq_c = (a_i == b_i);
    assign lt_c = (a_i <  b_i);

endmodule

// File: rtl/stream_extrema_tracker.sv
// Framed-stream max/min/count tracker with a valid/ready result port.
// Optional STREAM_EXTREMA_INDEX_EN adds first-occurrence index outputs for max and min.
module stream_extrema_tracker
    import extrema_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_count,
`ifdef STREAM_EXTREMA_INDEX_EN
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_min_idx,
`endif
    output logic             out_ovf
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] omax_q, omax_d, omin_q, omin_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;
`ifdef STREAM_EXTREMA_INDEX_EN
    logic [CNT_W-1:0] maxi_q, maxi_d, mini_q, mini_d;
    logic [CNT_W-1:0] omaxi_q, omaxi_d, omini_q, omini_d;
`endif

    logic accept_c;
    logic max_gt, max_eq, max_lt;
    logic min_gt, min_eq, min_lt;
    logic max_upd_c, min_upd_c;

    magnitude_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .a_i  (in_data),
        .b_i  (max_q),
        .gt_c (max_gt),
        .eq_c (max_eq),
        .lt_c (max_lt)
    );

    magnitude_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .a_i  (in_data),
        .b_i  (min_q),
        .gt_c (min_gt),
        .eq_c (min_eq),
        .lt_c (min_lt)
    );

    // Strict comparisons only: ties never replace the stored extreme.
    assign max_upd_c = max_gt && !max_eq && !max_lt;
    assign min_upd_c = min_lt && !min_eq && !min_gt;

    assign in_ready = !rst && (state_q != ST_HOLD);
    assign accept_c = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        omax_d  = omax_q;
        omin_d  = omin_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
`ifdef STREAM_EXTREMA_INDEX_EN
        maxi_d  = maxi_q;
        mini_d  = mini_q;
        omaxi_d = omaxi_q;
        omini_d = omini_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    max_d   = in_data;
                    min_d   = in_data;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
`ifdef STREAM_EXTREMA_INDEX_EN
                    maxi_d  = '0;
                    mini_d  = '0;
`endif
                    state_d = in_last ? ST_HOLD : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept_c) begin
                    // cnt_q is the 0-based index of this sample, saturating with the count.
                    if (max_upd_c) begin
                        max_d  = in_data;
`ifdef STREAM_EXTREMA_INDEX_EN
                        maxi_d = cnt_q;
`endif
                    end
                    if (min_upd_c) begin
                        min_d  = in_data;
`ifdef STREAM_EXTREMA_INDEX_EN
                        mini_d = cnt_q;
`endif
                    end
                    if (cnt_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Snapshot the completed frame so results stay stable while the next frame runs.
        if (accept_c && in_last) begin
            omax_d  = max_d;
            omin_d  = min_d;
            ocnt_d  = cnt_d;
            oovf_d  = ovf_d;
`ifdef STREAM_EXTREMA_INDEX_EN
            omaxi_d = maxi_d;
            omini_d = mini_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            max_q   <= '0;
            min_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            omax_q  <= '0;
            omin_q  <= '0;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
`ifdef STREAM_EXTREMA_INDEX_EN
            maxi_q  <= '0;
            mini_q  <= '0;
            omaxi_q <= '0;
            omini_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            omax_q  <= omax_d;
            omin_q  <= omin_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
`ifdef STREAM_EXTREMA_INDEX_EN
            maxi_q  <= maxi_d;
            mini_q  <= mini_d;
            omaxi_q <= omaxi_d;
            omini_q <= omini_d;
`endif
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_max   = omax_q;
    assign out_min   = omin_q;
    assign out_count = ocnt_q;
    assign out_ovf   = oovf_q;
`ifdef STREAM_EXTREMA_INDEX_EN
    assign out_max_idx = omaxi_q;
    assign out_min_idx = omini_q;
`endif

endmodule

// File: tb/tb_stream_extrema_tracker.sv
// Directed bench for stream_extrema_tracker: frame table plus hand-written hold/reset/saturation sequences.
// Index outputs are checked when STREAM_EXTREMA_INDEX_EN is defined.
module tb_stream_extrema_tracker;

    typedef struct {
        int n;
        int gap;
        int d [5];
        int emax;
        int emin;
        int ecnt;
        int eovf;
        int emaxi;
        int emini;
    } frame_t;

    logic       clk;
    logic       rst;

    logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_ovf;
    logic [7:0] a_in_data, a_max, a_min, a_cnt;
    logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_ovf;
    logic [7:0] b_in_data, b_max, b_min;
    logic [1:0] b_cnt;
`ifdef STREAM_EXTREMA_INDEX_EN
    logic [7:0] a_max_idx, a_min_idx;
    logic [1:0] b_max_idx, b_min_idx;
`endif

    int n_tests;
    int n_fail;
    frame_t tbl [5];

    stream_extrema_tracker #(.WIDTH(8), .CNT_W(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_last   (a_in_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_max   (a_max),
        .out_min   (a_min),
        .out_count (a_cnt),
`ifdef STREAM_EXTREMA_INDEX_EN
        .out_max_idx (a_max_idx),
        .out_min_idx (a_min_idx),
`endif
        .out_ovf   (a_ovf)
    );

    stream_extrema_tracker #(.WIDTH(8), .CNT_W(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_max   (b_max),
        .out_min   (b_min),
        .out_count (b_cnt),
`ifdef STREAM_EXTREMA_INDEX_EN
        .out_max_idx (b_max_idx),
        .out_min_idx (b_min_idx),
`endif
        .out_ovf   (b_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input int n, input int gap,
                                  input int d0, input int d1, input int d2, input int d3, input int d4,
                                  input int emax, input int emin, input int ecnt, input int eovf,
                                  input int emaxi, input int emini);
        frame_t f;
        f.n = n; f.gap = gap;
        f.d[0] = d0; f.d[1] = d1; f.d[2] = d2; f.d[3] = d3; f.d[4] = d4;
        f.emax = emax; f.emin = emin; f.ecnt = ecnt; f.eovf = eovf;
        f.emaxi = emaxi; f.emini = emini;
        return f;
    endfunction

    // Drive one frame into DUT A, check the result one cycle after the last accept, then handshake.
    task automatic send_frame(input int k);
        frame_t f;
        f = tbl[k];
        for (int i = 0; i < f.n; i++) begin
            @(negedge clk);
            if (i == f.n - 1) check($sformatf("f%0d early_valid", k), int'(a_out_valid), 0);
            a_in_valid = 1'b1;
            a_in_data  = 8'(f.d[i]);
            a_in_last  = (i == f.n - 1);
            if (i != f.n - 1) begin
                for (int g = 0; g < f.gap; g++) begin
                    @(negedge clk);
                    a_in_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        check($sformatf("f%0d out_valid", k), int'(a_out_valid), 1);
        check($sformatf("f%0d in_ready", k), int'(a_in_ready), 0);
        check($sformatf("f%0d max", k), int'(a_max), f.emax);
        check($sformatf("f%0d min", k), int'(a_min), f.emin);
        check($sformatf("f%0d count", k), int'(a_cnt), f.ecnt);
        check($sformatf("f%0d ovf", k), int'(a_ovf), f.eovf);
`ifdef STREAM_EXTREMA_INDEX_EN
        check($sformatf("f%0d max_idx", k), int'(a_max_idx), f.emaxi);
        check($sformatf("f%0d min_idx", k), int'(a_min_idx), f.emini);
`endif
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check($sformatf("f%0d valid_drop", k), int'(a_out_valid), 0);
        check($sformatf("f%0d ready_back", k), int'(a_in_ready), 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tbl[0] = mk(4, 0, 15, 25, 10, 20, 0, 25, 10, 4, 0, 1, 2);
        tbl[1] = mk(3, 0, 45, 45, 45, 0, 0, 45, 45, 3, 0, 0, 0);
        tbl[2] = mk(5, 0, 7, 3, 9, 3, 9, 9, 3, 5, 0, 2, 1);
        tbl[3] = mk(2, 2, 0, 255, 0, 0, 0, 255, 0, 2, 0, 1, 0);
        tbl[4] = mk(2, 0, 151, 135, 0, 0, 0, 151, 135, 2, 0, 0, 1);

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = 8'd0; a_in_last = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 8'd0; b_in_last = 1'b0; b_out_ready = 1'b0;

        #12;
        check("rst out_valid", int'(a_out_valid), 0);
        check("rst in_ready", int'(a_in_ready), 0);
        check("rst max", int'(a_max), 0);
        check("rst count", int'(a_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst in_ready", int'(a_in_ready), 1);
        check("post_rst out_valid", int'(a_out_valid), 0);

        for (int k = 0; k < 4; k++) begin
            send_frame(k);
        end

        // Single-sample frame held by a stalled consumer; in_valid pulses must be ignored.
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 8'd200; a_in_last = 1'b1; a_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a_in_valid = (c % 2 == 0);
            a_in_data  = 8'd7;
            a_in_last  = 1'b1;
            check($sformatf("hold%0d out_valid", c), int'(a_out_valid), 1);
            check($sformatf("hold%0d in_ready", c), int'(a_in_ready), 0);
            check($sformatf("hold%0d max", c), int'(a_max), 200);
            check($sformatf("hold%0d min", c), int'(a_min), 200);
            check($sformatf("hold%0d count", c), int'(a_cnt), 1);
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_in_last = 1'b0;
        check("hold end valid", int'(a_out_valid), 1);
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check("hold hs valid_drop", int'(a_out_valid), 0);
        check("hold hs in_ready", int'(a_in_ready), 1);
        check("hold keep max", int'(a_max), 200);

        // Reset in the middle of a frame discards the partial data.
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 8'd95; a_in_last = 1'b0;
        @(negedge clk);
        a_in_data = 8'd100;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst max", int'(a_max), 0);
        check("midrst min", int'(a_min), 0);
        check("midrst count", int'(a_cnt), 0);
        check("midrst out_valid", int'(a_out_valid), 0);
        check("midrst in_ready", int'(a_in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(4);

        // Narrow counter: five samples saturate a 2-bit count.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            case (i)
                0: b_in_data = 8'd9;
                1: b_in_data = 8'd3;
                2: b_in_data = 8'd7;
                3: b_in_data = 8'd1;
                default: b_in_data = 8'd255;
            endcase
            b_in_last = (i == 4);
        end
        @(negedge clk);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        check("sat out_valid", int'(b_out_valid), 1);
        check("sat count", int'(b_cnt), 3);
        check("sat ovf", int'(b_ovf), 1);
        check("sat max", int'(b_max), 255);
        check("sat min", int'(b_min), 1);
`ifdef STREAM_EXTREMA_INDEX_EN
        check("sat max_idx", int'(b_max_idx), 3);
        check("sat min_idx", int'(b_min_idx), 3);
`endif
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check("sat valid_drop", int'(b_out_valid), 0);
        check("sat in_ready", int'(b_in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
